// File: rtl/hsdaoh_stream_arbiter.sv
// hsdaoh_stream_arbiter: round-robin burst scheduler sharing one 16-bit sample FIFO between streams
module hsdaoh_stream_arbiter #(
    parameter int NUM_STREAMS = 4,
    parameter int BURST_LEN   = 256
) (
    input  logic                      clk_pixel,
    input  logic                      rstn,
    input  logic [NUM_STREAMS-1:0]    stream_en,
    input  logic [NUM_STREAMS-1:0]    s_burst_rdy,
    input  logic [NUM_STREAMS-1:0]    s_valid,
    input  logic [16*NUM_STREAMS-1:0] s_data,
    input  logic [NUM_STREAMS-1:0]    s_drop,
    output logic [NUM_STREAMS-1:0]    s_ready,
    input  logic                      fifo_full,
    output logic                      fifo_wr_en,
    output logic [15:0]               fifo_wr_data,
    output logic                      busy,
    output logic [2:0]                grant_id
);
    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} state_t;
    localparam logic [3:0]  N4   = 4'(NUM_STREAMS);
    localparam logic [11:0] LAST = 12'(BURST_LEN - 1);

    state_t state, state_nxt;
    logic [2:0] rr_ptr, rr_nxt, pick;
    logic found, xfer, hdr_wr, last;
    logic [3:0] sum, sum_g;
    logic [11:0] cnt;
    logic [7:0] seq [8];
    logic [7:0] ovf, valid8, drop8, hdr_clr, ready8;
    logic [15:0] words [8];
    logic [2*NUM_STREAMS-1:0] rot;

    // Pad per-stream vectors to eight entries so a 3-bit grant index is always in range
    for (genvar i = 0; i < 8; i++) begin : g_words
        if (i < NUM_STREAMS) begin : g_act
            assign words[i] = s_data[16*i +: 16];
        end else begin : g_pad
            assign words[i] = 16'h0000;
        end
    end

    assign valid8 = 8'(s_valid);
    assign drop8  = 8'(s_drop);
    assign rot    = {stream_en & s_burst_rdy, stream_en & s_burst_rdy} >> rr_ptr;

    // Descending scan so the eligible stream closest to rr_ptr wins
    always_comb begin
        found = 1'b0;
        sum   = 4'd0;
        for (int k = NUM_STREAMS - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                sum   = {1'b0, rr_ptr} + 4'(k);
            end
        end
        pick  = sum >= N4 ? 3'(sum - N4) : sum[2:0];
        sum_g = {1'b0, pick} + 4'd1;
        rr_nxt = sum_g == N4 ? 3'd0 : sum_g[2:0];
    end

    always_comb begin
        hdr_wr       = state == HEADER && !fifo_full;
        xfer         = state == PAYLOAD && valid8[grant_id] && !fifo_full;
        last         = xfer && cnt == LAST;
        fifo_wr_en   = hdr_wr || xfer;
        fifo_wr_data = hdr_wr ? {4'hC, grant_id, ovf[grant_id], seq[grant_id]} :
                       xfer   ? words[grant_id] : 16'h0000;
        ready8       = xfer ? 8'd1 << grant_id : 8'd0;
        hdr_clr      = hdr_wr ? 8'd1 << grant_id : 8'd0;
        s_ready      = ready8[NUM_STREAMS-1:0];
        busy         = state != IDLE;
        state_nxt    = state == IDLE   ? (found ? HEADER : IDLE) :
                       state == HEADER ? (hdr_wr ? PAYLOAD : HEADER) :
                                         (last ? IDLE : PAYLOAD);
    end

    always_ff @(posedge clk_pixel or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk_pixel or negedge rstn) begin
        if (!rstn) begin
            grant_id <= 3'd0;
            rr_ptr   <= 3'd0;
            cnt      <= 12'd0;
            ovf      <= 8'd0;
            for (int k = 0; k < 8; k++) seq[k] <= 8'd0;
        end else begin
            if (state == IDLE && found) begin
                grant_id <= pick;
                rr_ptr   <= rr_nxt;
            end
            if (hdr_wr) cnt <= 12'd0;
            else if (xfer) cnt <= cnt + 12'd1;
            if (last) seq[grant_id] <= seq[grant_id] + 8'd1;
            // A drop landing on the header-write cycle survives the clear
            ovf <= (ovf & ~hdr_clr) | drop8;
        end
    end
endmodule

// File: tb/tb_hsdaoh_stream_arbiter.sv
// tb_hsdaoh_stream_arbiter: directed scenario bench for the round-robin FIFO arbiter
module tb_hsdaoh_stream_arbiter;
    localparam int NS = 4;
    localparam int BL = 4;
    localparam logic [15:0] EXP_SINGLE [10] = '{16'hC400, 16'h1000, 16'h1001, 16'h1002, 16'h1003,
                                                16'hC401, 16'h1004, 16'h1005, 16'h1006, 16'h1007};
    localparam logic [15:0] EXP_RR  [6] = '{16'hC000, 16'hC200, 16'hC600, 16'hC001, 16'hC201, 16'hC601};
    localparam logic [15:0] EXP_BP  [5] = '{16'hC000, 16'h5000, 16'h5001, 16'h5002, 16'h5003};
    localparam logic [15:0] EXP_OVF [4] = '{16'hC300, 16'hC201, 16'hC302, 16'hC203};

    logic clk_pixel = 1'b0;
    logic rstn;
    logic [NS-1:0] stream_en, s_burst_rdy, s_valid, s_drop, s_ready;
    logic [16*NS-1:0] s_data;
    logic fifo_full, fifo_wr_en, busy;
    logic [15:0] fifo_wr_data;
    logic [2:0] grant_id;
    logic [15:0] base [NS];
    logic [15:0] ptr [NS];
    logic [15:0] log_q [$];
    int cyc_q [$];
    int cyc = 0;
    int tests = 0;
    int fails = 0;
    logic watch2 = 1'b0;
    logic saw2 = 1'b0;

    always #5 clk_pixel = ~clk_pixel;

    hsdaoh_stream_arbiter #(.NUM_STREAMS(NS), .BURST_LEN(BL)) dut (
        .clk_pixel(clk_pixel), .rstn(rstn), .stream_en(stream_en), .s_burst_rdy(s_burst_rdy),
        .s_valid(s_valid), .s_data(s_data), .s_drop(s_drop), .s_ready(s_ready),
        .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
        .busy(busy), .grant_id(grant_id)
    );

    always_comb begin
        for (int i = 0; i < NS; i++) s_data[16*i +: 16] = base[i] + ptr[i];
    end

    always @(posedge clk_pixel or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NS; i++) ptr[i] <= 16'd0;
        end else begin
            for (int i = 0; i < NS; i++) if (s_ready[i]) ptr[i] <= ptr[i] + 16'd1;
        end
    end

    always @(posedge clk_pixel) cyc <= cyc + 1;

    always @(negedge clk_pixel) begin
        if (rstn && fifo_wr_en) begin
            log_q.push_back(fifo_wr_data);
            cyc_q.push_back(cyc);
        end
        if (watch2 && busy && grant_id == 3'd2) saw2 <= 1'b1;
    end

    task automatic do_reset();
        rstn = 1'b0;
        stream_en = '0; s_burst_rdy = '0; s_valid = '0; s_drop = '0; fifo_full = 1'b0;
        for (int i = 0; i < NS; i++) base[i] = 16'h0000;
        repeat (2) @(posedge clk_pixel);
        #1;
        rstn = 1'b1;
        log_q.delete();
        cyc_q.delete();
    endtask

    task automatic wait_log(input int n, input int budget);
        for (int k = 0; k < budget && log_q.size() < n; k++) begin
            @(posedge clk_pixel);
            #1;
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        stream_en = '1; s_burst_rdy = '1; s_valid = '1; s_drop = '1; fifo_full = 1'b0;
        repeat (3) @(posedge clk_pixel);
        #1;
        tests++; if (fifo_wr_en !== 1'b0) begin fails++; $display("FAIL reset_wr_en: got %b, expected 0", fifo_wr_en); end
        tests++; if (fifo_wr_data !== 16'h0000) begin fails++; $display("FAIL reset_wr_data: got %h, expected 0000", fifo_wr_data); end
        tests++; if (s_ready !== 4'b0000) begin fails++; $display("FAIL reset_s_ready: got %b, expected 0000", s_ready); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        tests++; if (grant_id !== 3'd0) begin fails++; $display("FAIL reset_grant_id: got %0d, expected 0", grant_id); end
    endtask

    task automatic test_single_stream();
        int start;
        do_reset();
        base[2] = 16'h1000;
        stream_en = 4'b0100; s_burst_rdy = 4'b0100; s_valid = 4'b0100;
        start = cyc;
        wait_log(10, 100);
        tests++;
        if (log_q.size() < 10) begin
            fails++; $display("FAIL single_count: got %0d writes, expected 10", log_q.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                tests++;
                if (log_q[i] !== EXP_SINGLE[i]) begin
                    fails++; $display("FAIL single_word%0d: got %h, expected %h", i, log_q[i], EXP_SINGLE[i]);
                end
            end
            tests++; if (cyc_q[0] - start != 1) begin fails++; $display("FAIL single_latency: got %0d, expected 1", cyc_q[0] - start); end
            tests++; if (cyc_q[5] - cyc_q[0] != BL + 2) begin fails++; $display("FAIL single_burst_cycles: got %0d, expected %0d", cyc_q[5] - cyc_q[0], BL + 2); end
        end
    endtask

    task automatic test_round_robin();
        logic [15:0] hdr [$];
        do_reset();
        watch2 = 1'b1;
        stream_en = 4'b1011; s_burst_rdy = 4'b1011; s_valid = 4'b1111;
        wait_log(30, 200);
        foreach (log_q[i]) if (log_q[i][15:12] == 4'hC) hdr.push_back(log_q[i]);
        tests++;
        if (hdr.size() < 6) begin
            fails++; $display("FAIL rr_count: got %0d headers, expected 6", hdr.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                tests++;
                if (hdr[i] !== EXP_RR[i]) begin fails++; $display("FAIL rr_header%0d: got %h, expected %h", i, hdr[i], EXP_RR[i]); end
            end
        end
        tests++; if (saw2 !== 1'b0) begin fails++; $display("FAIL rr_disabled_stream: got granted=%b, expected 0", saw2); end
        watch2 = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset();
        base[0] = 16'h5000;
        stream_en = 4'b0001; s_burst_rdy = 4'b0001; s_valid = 4'b0001;
        @(posedge clk_pixel); #1;
        fifo_full = 1'b1;
        repeat (3) begin
            @(negedge clk_pixel);
            tests++;
            if (fifo_wr_en !== 1'b0 || s_ready !== 4'b0000 || busy !== 1'b1) begin
                fails++; $display("FAIL bp_header_hold: got wr_en=%b ready=%b busy=%b, expected 0 0000 1", fifo_wr_en, s_ready, busy);
            end
            @(posedge clk_pixel); #1;
        end
        fifo_full = 1'b0;
        stream_en = 4'b0000; s_burst_rdy = 4'b0000;
        repeat (3) begin @(posedge clk_pixel); #1; end
        fifo_full = 1'b1;
        repeat (3) begin
            @(negedge clk_pixel);
            tests++;
            if (fifo_wr_en !== 1'b0 || s_ready !== 4'b0000) begin
                fails++; $display("FAIL bp_payload_hold: got wr_en=%b ready=%b, expected 0 0000", fifo_wr_en, s_ready);
            end
            @(posedge clk_pixel); #1;
        end
        fifo_full = 1'b0;
        repeat (10) begin @(posedge clk_pixel); #1; end
        tests++;
        if (log_q.size() != 5) begin
            fails++; $display("FAIL bp_count: got %0d writes, expected 5", log_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                tests++;
                if (log_q[i] !== EXP_BP[i]) begin fails++; $display("FAIL bp_word%0d: got %h, expected %h", i, log_q[i], EXP_BP[i]); end
            end
        end
        tests++; if (ptr[0] !== 16'd4) begin fails++; $display("FAIL bp_consumed: got %0d, expected 4", ptr[0]); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL bp_idle_after: got %b, expected 0", busy); end
    endtask

    task automatic test_overflow();
        logic [15:0] hdr [$];
        int n1 = 0;
        logic dropped0 = 1'b0;
        do_reset();
        stream_en = 4'b0011; s_burst_rdy = 4'b0011; s_valid = 4'b0011;
        for (int k = 0; k < 200 && n1 < 4; k++) begin
            @(posedge clk_pixel); #1;
            s_drop = 4'b0000;
            if (fifo_wr_en && fifo_wr_data[15:12] == 4'hC && grant_id == 3'd1) begin
                if (n1 == 1) s_drop = 4'b0010;
                n1++;
            end else if (!dropped0 && fifo_wr_en && grant_id == 3'd0 && fifo_wr_data[15:12] != 4'hC) begin
                s_drop = 4'b0010;
                dropped0 = 1'b1;
            end
        end
        @(negedge clk_pixel); #1;
        s_drop = 4'b0000;
        foreach (log_q[i]) if (log_q[i][15:12] == 4'hC && log_q[i][11:9] == 3'd1) hdr.push_back(log_q[i]);
        tests++;
        if (hdr.size() < 4) begin
            fails++; $display("FAIL ovf_count: got %0d stream1 headers, expected 4", hdr.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests++;
                if (hdr[i] !== EXP_OVF[i]) begin fails++; $display("FAIL ovf_header%0d: got %h, expected %h", i, hdr[i], EXP_OVF[i]); end
            end
        end
    endtask

    task automatic test_seq_wrap();
        logic [15:0] hdr [$];
        logic [15:0] want;
        do_reset();
        stream_en = 4'b0001; s_burst_rdy = 4'b0001; s_valid = 4'b0001;
        wait_log(257 * (BL + 1), 2000);
        foreach (log_q[i]) if (log_q[i][15:12] == 4'hC) hdr.push_back(log_q[i]);
        tests++;
        if (hdr.size() < 257) begin
            fails++; $display("FAIL seq_count: got %0d headers, expected 257", hdr.size());
        end else begin
            for (int i = 0; i < 257; i++) begin
                want = {8'hC0, 8'(i)};
                tests++;
                if (hdr[i] !== want) begin fails++; $display("FAIL seq_header%0d: got %h, expected %h", i, hdr[i], want); end
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        stream_en = 4'b0011; s_burst_rdy = 4'b0011; s_valid = 4'b0011;
        wait_log(8, 100);
        tests++; if (grant_id !== 3'd1 || !busy) begin fails++; $display("FAIL rst_mid_setup: got grant=%0d busy=%b, expected 1 1", grant_id, busy); end
        rstn = 1'b0;
        #1;
        tests++; if (fifo_wr_en !== 1'b0) begin fails++; $display("FAIL rst_mid_wr_en: got %b, expected 0", fifo_wr_en); end
        tests++; if (fifo_wr_data !== 16'h0000) begin fails++; $display("FAIL rst_mid_wr_data: got %h, expected 0000", fifo_wr_data); end
        tests++; if (s_ready !== 4'b0000) begin fails++; $display("FAIL rst_mid_s_ready: got %b, expected 0000", s_ready); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_mid_busy: got %b, expected 0", busy); end
        tests++; if (grant_id !== 3'd0) begin fails++; $display("FAIL rst_mid_grant_id: got %0d, expected 0", grant_id); end
        repeat (2) @(posedge clk_pixel);
        #1;
        log_q.delete();
        cyc_q.delete();
        rstn = 1'b1;
        wait_log(1, 20);
        tests++;
        if (log_q.size() < 1) begin
            fails++; $display("FAIL rst_mid_regrant: got no write, expected header c000");
        end else if (log_q[0] !== 16'hC000) begin
            fails++; $display("FAIL rst_mid_regrant: got %h, expected c000", log_q[0]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < NS; i++) base[i] = 16'h0000;
        test_reset();
        test_single_stream();
        test_round_robin();
        test_backpressure();
        test_overflow();
        test_seq_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/hsdaoh_stream_arbiter.md
# hsdaoh_stream_arbiter

Round-robin scheduler that shares the single 16-bit hsdaoh sample FIFO between up to eight independent data streams (e.g. several ADC channels or auxiliary data). It sits on the write side of the shared FIFO that feeds the HDMI output core. It grants one stream at a time for a fixed-length burst and prefixes every burst with a header word, so the host can demultiplex streams and detect drops.

## Interface
- NUM_STREAMS, 4, number of requesters, legal range 2..8.
- BURST_LEN, 256, payload words per burst, legal range 2..4095.
- clk_pixel  input  1  block clock, shared with the FIFO write port.
- rstn  input  1  asynchronous, active-low reset.
- stream_en  input  NUM_STREAMS  per-stream enable (configuration, quasi-static).
- s_burst_rdy  input  NUM_STREAMS  stream i has at least BURST_LEN words buffered.
- s_valid  input  NUM_STREAMS  stream i current word valid.
- s_data  input  16*NUM_STREAMS  stream i word in bits [16*i+15:16*i].
- s_drop  input  NUM_STREAMS  one-cycle pulse: stream i upstream lost a sample.
- s_ready  output  NUM_STREAMS  word of stream i consumed this cycle.
- fifo_full  input  1  shared FIFO cannot accept a write.
- fifo_wr_en  output  1  write strobe to shared FIFO.
- fifo_wr_data  output  16  write data to shared FIFO.
- busy  output  1  burst in progress (state not IDLE).
- grant_id  output  3  index of the currently or last granted stream.

## Operation
- FSM states: IDLE, HEADER, PAYLOAD.
- IDLE: eligible[i] = stream_en[i] & s_burst_rdy[i]. The first eligible stream, searched from rr_ptr upward mod NUM_STREAMS, is latched into grant_id, and the state goes to HEADER. With no eligible stream, the state stays IDLE.
- rr_ptr = (grant_id + 1) mod NUM_STREAMS after each grant. After reset rr_ptr = 0, so stream 0 has first priority.
- HEADER: when !fifo_full, write header {4'hC, grant_id[2:0], ovf[g], seq[g][7:0]}, clear cnt, and go to PAYLOAD. When fifo_full, hold the state.
- PAYLOAD: transfer = s_valid[g] & !fifo_full. On a transfer: fifo_wr_en=1, fifo_wr_data=s_data[g], s_ready[g]=1, cnt+1.
- On the transfer with cnt == BURST_LEN-1: seq[g] increments, and the state goes to IDLE.
- s_valid low mid-burst: the block waits indefinitely and writes nothing. There is no partial burst and no timeout.
- seq[i]: 8-bit per-stream burst sequence counter, wraps 255 to 0.
- ovf[i]: sticky flag, set by s_drop[i]. It is cleared on the cycle the header carrying it is written.
  - If s_drop[i] arrives in that same cycle, ovf[i] stays 1 for the next header.
- stream_en[g] deasserted during HEADER/PAYLOAD: the burst still completes. The enable is only sampled in IDLE.
- s_ready bits for non-granted streams are always 0. s_ready is never 1 while fifo_full is 1.

## Timing
- Reset values: fifo_wr_en=0, fifo_wr_data=16'h0000, s_ready=0, busy=0, grant_id=0, state=IDLE, rr_ptr=0, all seq=0, all ovf=0, cnt=0.
- fifo_wr_en, fifo_wr_data and s_ready are combinational from state/s_valid/fifo_full/s_data. All other state is registered on the rising edge of clk_pixel.
- Arbitration latency: one cycle from eligible (seen in IDLE) to HEADER. The header is written in the next cycle if not full.
- Minimum burst duration: BURST_LEN+2 cycles (IDLE, HEADER, BURST_LEN payload cycles). There is no gap state after the last payload word.
- cnt is 12 bits. The comparison uses BURST_LEN-1 at full width.
- rstn assertion mid-burst aborts it immediately; all outputs go to their reset values asynchronously. A partial burst already in the FIFO is not repaired; the host detects it by the missing header/sequence.

## Test plan
- Single stream: NUM_STREAMS=4, BURST_LEN=4, only stream 2 enabled and ready, data 0x1000.. -> FIFO receives 0xC400, 0x1000, 0x1001, 0x1002, 0x1003, then 0xC401 for the next burst. Burst takes 6 cycles.
- Round robin: streams 0,1,3 continuously eligible -> header IDs in order 0,1,3,0,1,3. Stream 2 is never granted while stream_en[2]=0.
- Backpressure: assert fifo_full for 3 cycles during HEADER and again mid-payload. Required:
  - no writes and s_ready=0 while full;
  - word order and count intact;
  - the burst completes exactly BURST_LEN payload words.
- Overflow flag:
  - s_drop[1] pulse during a stream-0 burst -> next stream-1 header has bit8=1; the following stream-1 header has bit8=0.
  - s_drop[1] in the same cycle as the stream-1 header write -> the following stream-1 header has bit8=1.
- Sequence wrap: 257 bursts of stream 0 -> sequence field 0x00..0xFF, then 0x00.
- Reset mid-payload: deassert rstn after 2 of 4 payload words -> outputs go to their reset values immediately. After release, stream 0 is granted first, with header 0xC000.
